// File: rtl/vpu_vec_pack_if.sv
// rtl/vpu_vec_pack_if.sv - element input and vector output handshake bundle for vpu_vec_pack
//
// Signals:
//   in_valid/in_ready/in_data/in_last : one SEW-wide element per accepted cycle
//   out_valid/out_ready/out_flat/out_count : packed VLEN-wide vector and lane count
// Modports: master drives elements and consumes vectors; slave is the packer.

`ifndef VLEN
`define VLEN 32
`endif
`ifndef SEW
`define SEW 8
`endif

interface vpu_vec_pack_if;
    logic                            in_valid;
    logic                            in_ready;
    logic [`SEW-1:0]                 in_data;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic [`VLEN-1:0]                out_flat;
    logic [$clog2(`VLEN/`SEW):0]     out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_flat, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_flat, out_count
    );
endinterface

// File: rtl/vpu_vec_pack.sv
// rtl/vpu_vec_pack.sv - packs a stream of SEW-wide elements into VLEN-wide lane-ordered vectors
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : vpu_vec_pack_if.slave (element input stream, packed vector output)
// Lane i of out_flat sits at [i*SEW +: SEW]; lanes past out_count read zero.

`ifndef VLEN
`define VLEN 32
`endif
`ifndef SEW
`define SEW 8
`endif

module vpu_vec_pack (
    input  logic          clk,
    input  logic          rst,
    vpu_vec_pack_if.slave bus
);
    localparam int VLEN  = `VLEN;
    localparam int SEW   = `SEW;
    localparam int LANES = VLEN / SEW;
    localparam int CW    = $clog2(LANES) + 1;
    localparam int IW    = CW - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [VLEN-1:0] fill;
    logic [VLEN-1:0] out_flat_q;
    logic [CW-1:0]   out_count_q;
    logic            out_valid_q;

    logic            accept;
    logic            complete;
    logic            slot_free;
    logic            transfer;
    logic [VLEN-1:0] merged;

    // in_ready depends only on registered state, never on out_ready.
    assign bus.in_ready  = (state == FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_flat  = out_flat_q;
    assign bus.out_count = out_count_q;

    always_comb begin
        accept    = bus.in_valid && (state == FILL);
        complete  = accept && ((idx == LAST_IDX) || bus.in_last);
        slot_free = !out_valid_q || bus.out_ready;
        // In HOLD the completed vector is already in fill; in FILL the
        // completing element is merged in so it can go straight out.
        transfer  = ((state == FILL) && complete && slot_free) ||
                    ((state == HOLD) && slot_free);
        merged    = fill;
        for (int i = 0; i < LANES; i++) begin
            if (accept && (idx == IW'(i))) begin
                merged[i*SEW +: SEW] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            fill        <= '0;
            out_flat_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else if (transfer) begin
            out_flat_q  <= merged;
            out_count_q <= {1'b0, idx} + CW'(1);
            out_valid_q <= 1'b1;
            // Clearing fill here is what zero-pads lanes of an early-closed vector.
            fill        <= '0;
            idx         <= '0;
            state       <= FILL;
        end else begin
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                fill <= merged;
                // idx is left on the final lane in HOLD so out_count = idx+1 on release.
                if (complete) begin
                    state <= HOLD;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vpu_vec_pack.sv
// tb/tb_vpu_vec_pack.sv - directed self-checking bench for vpu_vec_pack (VLEN=32, SEW=8)

`ifndef VLEN
`define VLEN 32
`endif
`ifndef SEW
`define SEW 8
`endif

module tb_vpu_vec_pack;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vpu_vec_pack_if bus ();

    vpu_vec_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves the element driven for exactly one posedge
    // and returns at the following negedge with in_valid low.
    task automatic send(input logic [7:0] data, input logic last);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_flat",  bus.out_flat,       32'h0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);

        // full vector, one-cycle valid pulse
        bus.out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check("full_valid", 32'(bus.out_valid), 32'd1);
        check("full_flat",  bus.out_flat,       32'h04030201);
        check("full_count", 32'(bus.out_count), 32'd4);
        @(negedge clk);
        check("full_pulse", 32'(bus.out_valid), 32'd0);

        // early close and lane restart
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        check("last_flat",  bus.out_flat,       32'h00002211);
        check("last_count", 32'(bus.out_count), 32'd2);
        send(8'h33, 1'b1);
        check("lane0_flat",  bus.out_flat,       32'h00000033);
        check("lane0_count", 32'(bus.out_count), 32'd1);
        @(negedge clk);

        // backpressure: output register plus held fill buffer
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send(8'(k), 1'b0);
        check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_held_flat", bus.out_flat,       32'h04030201);
        @(negedge clk);
        check("bp_stable",    bus.out_flat,       32'h04030201);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_flat",     bus.out_flat,       32'h08070605);
        check("bp_rel_count",    32'(bus.out_count), 32'd4);
        check("bp_rel_in_ready", 32'(bus.in_ready),  32'd1);
        check("bp_rel_valid",    32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // continuous stream, no bubbles
        for (int i = 0; i < 12; i++) begin
            check($sformatf("cont_in_ready_%0d", i), 32'(bus.in_ready), 32'd1);
            check($sformatf("cont_valid_%0d", i), 32'(bus.out_valid), 32'((i == 4) || (i == 8)));
            if (i == 4) check("cont_v0", bus.out_flat, 32'h03020100);
            if (i == 8) check("cont_v1", bus.out_flat, 32'h07060504);
            send(8'(i), 1'b0);
        end
        check("cont_v2",       bus.out_flat,       32'h0B0A0908);
        check("cont_v2_valid", 32'(bus.out_valid), 32'd1);

        // back-to-back single-lane vectors
        send(8'hA1, 1'b1);
        check("one_a1", bus.out_flat, 32'h000000A1);
        send(8'hA2, 1'b1);
        check("one_a2", bus.out_flat, 32'h000000A2);
        check("one_a2_valid", 32'(bus.out_valid), 32'd1);
        send(8'hA3, 1'b1);
        check("one_a3", bus.out_flat, 32'h000000A3);
        check("one_a3_count", 32'(bus.out_count), 32'd1);
        @(negedge clk);

        // reset with a pending vector and a partial fill
        bus.out_ready = 1'b0;
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        send(8'h53, 1'b0);
        send(8'h54, 1'b0);
        send(8'h55, 1'b0);
        send(8'h56, 1'b0);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_flat",  bus.out_flat,       32'h0);
        check("arst_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        check("post_rst_flat",  bus.out_flat,       32'h24232221);
        check("post_rst_count", 32'(bus.out_count), 32'd4);
        check("post_rst_valid", 32'(bus.out_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vpu_vec_pack.md
# vpu_vec_pack

Stream-to-vector packer feeding the VPU reduction path. It accepts `SEW`-wide scalar elements one per cycle over a valid/ready handshake and assembles them into a flattened `VLEN`-wide vector in lane order. Completed vectors are presented on a valid/ready output port whose data layout matches the adder-tree input (`in_flat`). A partial vector can be closed early with `in_last`; unused lanes are zero-padded so a downstream sum is unaffected.

## Interface
- `VLEN` (macro, `config_sys.vh`): vector width in bits.
- `SEW` (macro, `config_sys.vh`): element width in bits.
- `LANES` (localparam): `VLEN/SEW`. Power of two, ≥ 2.
- `CW` (localparam): `$clog2(LANES)+1`. Width of the lane count.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: element valid.
- `in_ready`, output, 1: packer can accept an element.
- `in_data`, input, `SEW`: element value.
- `in_last`, input, 1: the element is the last of its vector and closes it early. Qualified by `in_valid`.
- `out_valid`, output, 1: a packed vector is available.
- `out_ready`, input, 1: downstream accepts the vector.
- `out_flat`, output, `VLEN`: packed vector. Lane i is at `[i*SEW +: SEW]`.
- `out_count`, output, `CW`: number of populated lanes, 1..`LANES`.

## Operation
- Internal storage is a fill buffer (`LANES` × `SEW`), a lane index `idx` (`CW-1` bits), and an output register (`out_flat`, `out_count`, `out_valid`).
- An element is accepted when `in_valid && in_ready`. It is written to fill lane `idx`, then `idx` increments.
- A vector is complete when the accepted element has `idx == LANES-1` or `in_last == 1`. Both conditions together count as a single completion.
- Fill lanes not written before completion read as zero; the fill buffer is cleared on every transfer.
- State machine:
  - **FILL**: `in_ready = 1`.
    - On completion, if the output slot is free (`!out_valid || out_ready`), transfer the fill buffer to the output register, set `out_count = idx+1`, reset `idx` to 0, and stay in FILL.
    - On completion with the slot busy, go to HOLD.
  - **HOLD**: `in_ready = 0`. The completed vector is held in the fill buffer.
    - When `!out_valid || out_ready`, transfer, reset `idx` to 0, and go to FILL.
- Output handshake:
  - `out_valid` clears on `out_valid && out_ready` unless a transfer occurs in the same cycle, in which case it stays 1 with the new data.
  - `out_flat` and `out_count` are stable while `out_valid && !out_ready`.
- `in_last` on an element with `idx == 0` produces a vector with `out_count = 1`, lanes 1..`LANES-1` zero.
- `in_data` and `in_last` are ignored when `in_ready == 0` or `in_valid == 0`.
- Reset mid-operation discards the partial fill, any held vector, and the undelivered output, with no flush.

## Timing
- Reset values: `out_valid = 0`, `out_flat = 0`, `out_count = 0`, `idx = 0`, fill buffer = 0, state = FILL, so `in_ready = 1`.
- `in_ready` is a registered-state decode (state == FILL). It has no combinational path from `out_ready`.
- Latency: when the completing element is accepted in cycle t, `out_valid` is 1 in cycle t+1, provided the slot is free at t.
- Throughput: with `out_ready` held at 1, one element is accepted every cycle with no bubbles, giving one vector per `LANES` cycles. Back-to-back 1-lane vectors (`in_last` on every element) give one vector per cycle.
- From HOLD:
  - The transfer happens in the first cycle with a free slot, call it t.
  - `in_ready` returns to 1 in cycle t+1.
  - The new `out_valid`/data are visible in cycle t+1.
- Backpressure depth: one vector in the output register plus one complete vector in the fill buffer. After that, input stalls.

## Test plan
Examples use `VLEN = 32`, `SEW = 8` (`LANES = 4`).
- Reset, then idle → `in_ready = 1`, `out_valid = 0`, `out_flat = 0`, `out_count = 0`.
- Stream 0x01, 0x02, 0x03, 0x04 with `out_ready = 1` → one cycle after the 4th accept: `out_flat = 0x04030201`, `out_count = 4`, `out_valid` high for 1 cycle.
- Stream 0x11, 0x22 with `in_last` on 0x22 → `out_flat = 0x00002211`, `out_count = 2`. A following element 0x33 lands in lane 0.
- `out_ready = 0`; push 8 elements 0x01..0x08:
  - After the 8th, `in_ready = 0` and `out_flat = 0x04030201` is held.
  - Raise `out_ready` for 1 cycle → the next cycle shows `out_flat = 0x08070605` and `in_ready = 1`.
- Continuous stream 0x00..0x0B with `out_ready = 1` → 3 vectors on consecutive 4-cycle boundaries, `in_ready` never low.
- Assert `rst` after 2 accepted elements while a vector is pending on the output:
  - `out_valid`, `out_flat` and `out_count` go to 0 immediately.
  - After release, the next 4 elements form a clean vector with `out_count = 4`.
